// File: rtl/llsc_mem_unit_pkg.sv
// rtl/llsc_mem_unit_pkg.sv - shared types and constants for the LL/SC memory unit
// Holds the FSM state encoding, the decoded operation class, width defaults,
// the reset level and small decode helpers used by the unit and its bench.
package llsc_mem_unit_pkg;

    localparam int ADDR_W_DEFAULT = 32;
    localparam int DATA_W_DEFAULT = 32;

    // Reset is asserted when rst equals this level.
    localparam logic RST_ACTIVE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_LL   = 3'd1,
        OP_LW   = 3'd2,
        OP_SC   = 3'd3,
        OP_SW   = 3'd4
    } op_t;

    // The decoder upstream asserts at most one op strobe; a fixed priority
    // keeps behaviour defined if it ever asserts more than one.
    function automatic op_t decode_op(input logic ll, input logic sc,
                                      input logic lw, input logic sw);
        if (ll)      return OP_LL;
        else if (sc) return OP_SC;
        else if (lw) return OP_LW;
        else if (sw) return OP_SW;
        else         return OP_NONE;
    endfunction

    function automatic logic op_is_store(input op_t op);
        return (op == OP_SC) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/llsc_mem_unit_llbit_fwd.sv
// rtl/llsc_mem_unit_llbit_fwd.sv - forwarded (effective) LLbit mux
// Ports:
//   llbit_reg  - current LLbit register value
//   wb_we      - LLbit write happening in WB this cycle
//   wb_value   - value of that WB write
//   llbit_eff  - LLbit as seen by an instruction in MEM this cycle
module llsc_mem_unit_llbit_fwd (
    input  logic llbit_reg,
    input  logic wb_we,
    input  logic wb_value,
    output logic llbit_eff
);

    // A WB write lands in the register only at the end of this cycle, so it
    // must bypass the register to be visible to the instruction in MEM now.
    assign llbit_eff = wb_we ? wb_value : llbit_reg;

endmodule

// File: rtl/llsc_mem_unit.sv
// rtl/llsc_mem_unit.sv - MEM-stage executor for LL/SC/LW/SW with req/ack data bus
// Ports:
//   clk, rst (async, active-low), flush          - clock, reset, exception flush
//   op_ll/op_sc/op_lw/op_sw, addr_i, wdata_i     - current MEM instruction
//   LLbit_i, wb_LLbit_we_i, wb_LLbit_value_i     - LLbit register and WB bypass
//   bus_req_o/we_o/addr_o/wdata_o, bus_ack_i/rdata_i - data-bus handshake
//   result_o/result_valid_o                      - GPR result (load data / SC flag)
//   LLbit_we_o/LLbit_value_o                     - LLbit write toward MEM/WB
//   stallreq_o                                   - hold pipeline while bus busy
//   adel_o/ades_o                                - misaligned load / store
module llsc_mem_unit
    import llsc_mem_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              op_ll,
    input  logic              op_sc,
    input  logic              op_lw,
    input  logic              op_sw,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              LLbit_i,
    input  logic              wb_LLbit_we_i,
    input  logic              wb_LLbit_value_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic [DATA_W-1:0] result_o,
    output logic              result_valid_o,
    output logic              LLbit_we_o,
    output logic              LLbit_value_o,
    output logic              stallreq_o,
    output logic              adel_o,
    output logic              ades_o
);

    state_t            state;
    op_t               cur_op;
    op_t               lat_op;
    op_t               cap_op;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic              done_valid;
    logic [DATA_W-1:0] done_result;
    logic              done_llbit_we;
    logic              done_llbit_value;

    logic              eff_llbit;
    logic              misaligned;
    logic              idle_op;
    logic              sc_fail;
    logic              issue;
    logic              run;
    logic [DATA_W-1:0] cap_result;

    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic              llbit_we;
    logic              llbit_value;
    logic              stallreq;
    logic              adel;
    logic              ades;

    llsc_mem_unit_llbit_fwd u_llbit_fwd (
        .llbit_reg (LLbit_i),
        .wb_we     (wb_LLbit_we_i),
        .wb_value  (wb_LLbit_value_i),
        .llbit_eff (eff_llbit)
    );

    assign cur_op     = decode_op(op_ll, op_sc, op_lw, op_sw);
    assign misaligned = addr_i[1:0] != 2'b00;
    assign idle_op    = (state == ST_IDLE) && !flush && (cur_op != OP_NONE);
    assign sc_fail    = idle_op && !misaligned && (cur_op == OP_SC) && !eff_llbit;
    assign issue      = idle_op && !misaligned && !sc_fail;

    // An ack can arrive in the issuing IDLE cycle (bus answers the
    // combinational request at once), so capture uses the live op there.
    assign cap_op = (state == ST_IDLE) ? cur_op : lat_op;

    always_comb begin
        cap_result = '0;
        case (cap_op)
            OP_LL, OP_LW: cap_result = bus_rdata_i;
            OP_SC:        cap_result = DATA_W'(1);
            default:      cap_result = '0;
        endcase
    end

    always_comb begin
        bus_req      = 1'b0;
        bus_we       = 1'b0;
        bus_addr     = '0;
        bus_wdata    = '0;
        result       = '0;
        result_valid = 1'b0;
        llbit_we     = 1'b0;
        llbit_value  = 1'b0;
        stallreq     = 1'b0;
        adel         = 1'b0;
        ades         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (issue) begin
                    bus_req   = 1'b1;
                    bus_we    = op_is_store(cur_op);
                    bus_addr  = addr_i;
                    bus_wdata = op_is_store(cur_op) ? wdata_i : '0;
                    stallreq  = 1'b1;
                end else if (sc_fail) begin
                    // Failed SC resolves in place: flag 0, no LLbit write.
                    result_valid = 1'b1;
                end else if (idle_op) begin
                    // Only misaligned ops remain here.
                    adel = !op_is_store(cur_op);
                    ades = op_is_store(cur_op);
                end
            end
            ST_BUS: begin
                bus_req   = 1'b1;
                bus_we    = op_is_store(lat_op);
                bus_addr  = lat_addr;
                bus_wdata = lat_wdata;
                stallreq  = 1'b1;
            end
            ST_DONE: begin
                if (!flush) begin
                    result       = done_result;
                    result_valid = done_valid;
                    llbit_we     = done_llbit_we;
                    llbit_value  = done_llbit_value;
                end
            end
            ST_DRAIN: begin
                // Request withdrawn; waiting only for the orphaned ack.
            end
            default: begin
            end
        endcase
    end

    // Reset must silence outputs immediately, including the combinational
    // request that IDLE would otherwise raise for a waiting op.
    assign run            = (rst != RST_ACTIVE);
    assign bus_req_o      = run && bus_req;
    assign bus_we_o       = run && bus_we;
    assign bus_addr_o     = run ? bus_addr : '0;
    assign bus_wdata_o    = run ? bus_wdata : '0;
    assign result_o       = run ? result : '0;
    assign result_valid_o = run && result_valid;
    assign LLbit_we_o     = run && llbit_we;
    assign LLbit_value_o  = run && llbit_value;
    assign stallreq_o     = run && stallreq;
    assign adel_o         = run && adel;
    assign ades_o         = run && ades;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            state            <= ST_IDLE;
            lat_op           <= OP_NONE;
            lat_addr         <= '0;
            lat_wdata        <= '0;
            done_valid       <= 1'b0;
            done_result      <= '0;
            done_llbit_we    <= 1'b0;
            done_llbit_value <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        lat_op    <= cur_op;
                        lat_addr  <= addr_i;
                        lat_wdata <= bus_wdata;
                        state     <= bus_ack_i ? ST_DONE : ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (bus_ack_i) begin
                        // Flush with a same-cycle ack: the access completed
                        // but its result is architecturally dead.
                        state <= flush ? ST_IDLE : ST_DONE;
                    end else if (flush) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                ST_DRAIN: begin
                    if (bus_ack_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (bus_ack_i && (issue || (state == ST_BUS && !flush))) begin
                done_valid       <= (cap_op != OP_SW);
                done_result      <= cap_result;
                done_llbit_we    <= (cap_op == OP_LL) || (cap_op == OP_SC);
                done_llbit_value <= (cap_op == OP_LL);
            end
        end
    end

endmodule
